// File: rtl/bp_io_cmd_arbiter.sv
// Shares one I/O command/response channel pair among num_req_p requesters with credit limiting.
// Define BP_IO_CMD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bp_io_cmd_arbiter #(
    parameter int unsigned num_req_p     = 2,
    parameter int unsigned cmd_width_p   = 128,
    parameter int unsigned resp_width_p  = 128,
    parameter int unsigned max_credits_p = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p*cmd_width_p-1:0]   cmd_i,
    input  logic [num_req_p-1:0]               cmd_v_i,
    output logic [num_req_p-1:0]               cmd_ready_o,
    output logic [cmd_width_p-1:0]             cmd_o,
    output logic                               cmd_v_o,
    input  logic                               cmd_ready_i,
    input  logic [resp_width_p-1:0]            resp_i,
    input  logic                               resp_v_i,
    output logic                               resp_yumi_o,
    output logic [resp_width_p-1:0]            resp_o,
    output logic [num_req_p-1:0]               resp_v_o,
    input  logic [num_req_p-1:0]               resp_ready_i,
    output logic [$clog2(max_credits_p+1)-1:0] outstanding_o,
    output logic                               idle_o,
    output logic                               err_o
);

    localparam int unsigned IdxW = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned CntW = $clog2(max_credits_p + 1);
    localparam int unsigned PtrW = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;

    logic [cmd_width_p-1:0] cmd_q, cmd_d;
    logic                   cmd_v_q, cmd_v_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        rr_q, rr_d;
    logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic                   err_q, err_d;
    logic [IdxW-1:0]        order_q [max_credits_p];

    logic [IdxW-1:0]        grant;
    logic [cmd_width_p-1:0] grant_cmd;
    logic                   load, ne, yumi;
    logic [IdxW-1:0]        head;

    // In the fixed-priority build rr_q stays 0, so the scan start degenerates to index 0.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_cmd = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            idx = (32'(rr_q) + i) % num_req_p;
            if (!found && cmd_v_i[IdxW'(idx)]) begin
                grant = IdxW'(idx);
                found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (IdxW'(i) == grant) grant_cmd = cmd_i[i*cmd_width_p +: cmd_width_p];
        end
    end

    assign ne   = (cnt_q != '0);
    assign head = order_q[rptr_q];
    assign yumi = resp_v_i & ne & resp_ready_i[head];

    // A credit returning this cycle may be reused immediately, even at the limit.
    assign load = reset_n_i & (~cmd_v_q | cmd_ready_i)
                & ((cnt_q < CntW'(max_credits_p)) | yumi) & (|cmd_v_i);

    always_comb begin
        cmd_ready_o = '0;
        resp_v_o    = '0;
        if (load) cmd_ready_o[grant] = 1'b1;
        if (resp_v_i & ne) resp_v_o[head] = 1'b1;
    end

    always_comb begin
        cmd_d   = cmd_q;
        cmd_v_d = cmd_v_q;
        rr_d    = rr_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q | (resp_v_i & ~ne);
        if (load) begin
            cmd_d   = grant_cmd;
            cmd_v_d = 1'b1;
            wptr_d  = (wptr_q == PtrW'(max_credits_p - 1)) ? '0 : wptr_q + 1'b1;
`ifndef BP_IO_CMD_ARB_FIXED_PRIO_EN
            rr_d    = (grant == IdxW'(num_req_p - 1)) ? '0 : grant + 1'b1;
`endif
        end else if (cmd_ready_i) begin
            cmd_v_d = 1'b0;
        end
        if (yumi) rptr_d = (rptr_q == PtrW'(max_credits_p - 1)) ? '0 : rptr_q + 1'b1;
        case ({load, yumi})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_q   <= '0;
            cmd_v_q <= 1'b0;
            cnt_q   <= '0;
            rr_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            cmd_v_q <= cmd_v_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            err_q   <= err_d;
        end
    end

    // Order storage needs no reset: entries are only read while the count is non-zero.
    always_ff @(posedge clk_i) begin
        if (load) order_q[wptr_q] <= grant;
    end

    assign cmd_o         = cmd_q;
    assign cmd_v_o       = cmd_v_q;
    assign resp_o        = resp_i;
    assign resp_yumi_o   = yumi;
    assign outstanding_o = cnt_q;
    assign idle_o        = ~cmd_v_q & (cnt_q == '0);
    assign err_o         = err_q;

endmodule
